// File: rtl/aibcr3_dcc_cal_ctrl.sv
// DCC replica-path calibration sequencer: steps a coarse/fine delay code from averaged
// phase-detector decisions, locks on dither, and errors out at either end of the code range.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for cal_en with bypass released; code held
//   S_SETTLE | letting the delay line settle after a code change
//   S_SAMPLE | counting pd_up=1 cycles over AVG_N samples
//   S_STEP   | apply decision: +1/-1 code, dither tracking, lock/err check
//   S_LOCK   | dither seen LOCK_CNT times in a row; code frozen
//   S_ERR    | decision asked to step past min/max code; sticky
module aibcr3_dcc_cal_ctrl #(
   parameter int CRS_W      = 4,
   parameter int INIT_CODE  = 64,
   parameter int SETTLE_CYC = 16,
   parameter int AVG_N      = 8,
   parameter int LOCK_CNT   = 4
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             cal_en,
   input  logic             rb_dcc_byp,
   input  logic             pd_up,
   output logic [CRS_W-1:0] crs_code,
   output logic [6:0]       fine_sn,
   output logic [6:0]       fine_sp,
   output logic             cal_busy,
   output logic             cal_done,
   output logic             cal_err
);

   localparam int CW      = CRS_W + 3;
   localparam int CNT_MAX = (SETTLE_CYC > AVG_N) ? SETTLE_CYC : AVG_N;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int OW      = $clog2(AVG_N + 1);
   localparam int TW      = $clog2(LOCK_CNT + 1);

   localparam logic [CW-1:0]    INIT_C  = CW'(INIT_CODE);
   localparam logic [CW-1:0]    MAX_C   = {CW{1'b1}};
   localparam logic [OW-1:0]    HALF    = OW'(AVG_N / 2);
   localparam logic [CNT_W-1:0] SET_LD  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] SMP_LD  = CNT_W'(AVG_N - 1);
   localparam logic [TW-1:0]    LOCK_TC = TW'(LOCK_CNT);

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_STEP, S_LOCK, S_ERR} state_t;

   // Interpolator legs: fine=0 -> all n-legs on, fine=7 -> all off.
   function automatic logic [6:0] therm(input logic [2:0] f);
      logic [6:0] t;
      for (int i = 0; i < 7; i++) t[i] = (4'(i) < (4'd7 - {1'b0, f}));
      return t;
   endfunction

   state_t           state_q, state_d;
   logic [CW-1:0]    code_q, code_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OW-1:0]    ones_q, ones_d;
   logic [TW-1:0]    tog_q, tog_d;
   logic             pv_q, pv_d;
   logic             pup_q, pup_d;
   logic             is_up, is_dn, dither;

   assign is_up  = (ones_q > HALF);
   assign is_dn  = (ones_q < HALF);
   assign dither = (!is_up && !is_dn) || (pv_q && (pup_q != is_up));

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      ones_d  = ones_q;
      tog_d   = tog_q;
      pv_d    = pv_q;
      pup_d   = pup_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_SETTLE;
            cnt_d   = SET_LD;
            tog_d   = '0;
            pv_d    = 1'b0;
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = S_SAMPLE;
               cnt_d   = SMP_LD;
               ones_d  = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_SAMPLE: begin
            ones_d = ones_q + OW'(pd_up);
            if (cnt_q == '0) state_d = S_STEP;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_STEP: begin
            if ((is_up && code_q == MAX_C) || (is_dn && code_q == '0)) begin
               state_d = S_ERR;
            end else begin
               if (is_up) code_d = code_q + CW'(1);
               if (is_dn) code_d = code_q - CW'(1);
               if (dither)    tog_d = tog_q + TW'(1);
               else if (pv_q) tog_d = '0;
               if (is_up || is_dn) begin
                  pv_d  = 1'b1;
                  pup_d = is_up;
               end
               state_d = (tog_d == LOCK_TC) ? S_LOCK : S_SETTLE;
               cnt_d   = SET_LD;
            end
         end
         default: ;
      endcase
      // Bypass and enable loss override everything and freeze the code.
      if (rb_dcc_byp || !cal_en) begin
         state_d = S_IDLE;
         code_d  = code_q;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q  <= S_IDLE;
         code_q   <= INIT_C;
         cnt_q    <= '0;
         ones_q   <= '0;
         tog_q    <= '0;
         pv_q     <= 1'b0;
         pup_q    <= 1'b0;
         fine_sn  <= therm(INIT_C[2:0]);
         fine_sp  <= ~therm(INIT_C[2:0]);
         cal_busy <= 1'b0;
         cal_done <= 1'b0;
         cal_err  <= 1'b0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         cnt_q    <= cnt_d;
         ones_q   <= ones_d;
         tog_q    <= tog_d;
         pv_q     <= pv_d;
         pup_q    <= pup_d;
         fine_sn  <= therm(code_d[2:0]);
         fine_sp  <= ~therm(code_d[2:0]);
         cal_busy <= (state_d == S_SETTLE) || (state_d == S_SAMPLE) || (state_d == S_STEP);
         cal_done <= (state_d == S_LOCK);
         cal_err  <= (state_d == S_ERR);
      end
   end

   assign crs_code = code_q[CW-1:3];

endmodule

// File: tb/tb_aibcr3_dcc_cal_ctrl.sv
// Bench for aibcr3_dcc_cal_ctrl: scenario table, hand-written corner sequences and a
// randomized run, all checked against an iteration-level reference model.
module tb_aibcr3_dcc_cal_ctrl;

   localparam int CRS_W = 4;
   localparam int INIT  = 64;
   localparam int SET   = 16;
   localparam int AVG   = 8;
   localparam int LCK   = 4;
   localparam int MAXC  = (1 << (CRS_W + 3)) - 1;

   logic             clk = 1'b0;
   logic             rstb = 1'b0;
   logic             cal_en = 1'b0;
   logic             rb_dcc_byp = 1'b0;
   logic             pd_up = 1'b0;
   logic [CRS_W-1:0] crs_code;
   logic [6:0]       fine_sn, fine_sp;
   logic             cal_busy, cal_done, cal_err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   aibcr3_dcc_cal_ctrl #(
      .CRS_W(CRS_W), .INIT_CODE(INIT), .SETTLE_CYC(SET), .AVG_N(AVG), .LOCK_CNT(LCK)
   ) dut (
      .clk(clk), .rstb(rstb), .cal_en(cal_en), .rb_dcc_byp(rb_dcc_byp), .pd_up(pd_up),
      .crs_code(crs_code), .fine_sn(fine_sn), .fine_sp(fine_sp),
      .cal_busy(cal_busy), .cal_done(cal_done), .cal_err(cal_err)
   );

   // Reference model: mode 0 idle, 1 running, 2 locked, 3 error.
   // m_t is the cycle position inside one iteration (settle, then samples, then the step).
   int m_mode, m_code, m_t, m_ones, m_tog, m_pdir;
   bit m_pv;

   function automatic void model_reset();
      m_mode = 0; m_code = INIT; m_t = 0; m_ones = 0; m_tog = 0; m_pv = 0; m_pdir = 0;
   endfunction

   function automatic void model_clock(input bit en, input bit byp, input bit pd);
      int dir;
      if (byp || !en) begin
         m_mode = 0;
         return;
      end
      if (m_mode == 0) begin
         m_mode = 1; m_t = 0; m_ones = 0; m_tog = 0; m_pv = 0;
      end else if (m_mode == 1) begin
         if (m_t < SET) m_t++;
         else if (m_t < SET + AVG) begin
            m_ones += int'(pd);
            m_t++;
         end else begin
            dir = (2 * m_ones > AVG) ? 1 : (2 * m_ones < AVG) ? -1 : 0;
            if ((dir == 1 && m_code == MAXC) || (dir == -1 && m_code == 0)) m_mode = 3;
            else begin
               m_code += dir;
               if (dir == 0 || (m_pv && dir != m_pdir)) m_tog++;
               else if (m_pv) m_tog = 0;
               if (dir != 0) begin
                  m_pv = 1; m_pdir = dir;
               end
               if (m_tog >= LCK) m_mode = 2;
               m_t = 0; m_ones = 0;
            end
         end
      end
   endfunction

   function automatic logic [6:0] sn_of(input int code);
      return 7'((1 << (7 - (code % 8))) - 1);
   endfunction

   task automatic check_model(input string tag);
      logic [CRS_W-1:0] ecrs;
      logic [6:0]       esn;
      logic             eb, ed, ee;
      ecrs = CRS_W'(m_code / 8);
      esn  = sn_of(m_code);
      eb = (m_mode == 1); ed = (m_mode == 2); ee = (m_mode == 3);
      n_cmp++;
      if ({crs_code, fine_sn, fine_sp, cal_busy, cal_done, cal_err} !== {ecrs, esn, ~esn, eb, ed, ee}) begin
         n_bad++;
         $display("FAIL %s cyc=%0d: got crs=%h sn=%h sp=%h bde=%b%b%b, want crs=%h sn=%h sp=%h bde=%b%b%b",
                  tag, cyc, crs_code, fine_sn, fine_sp, cal_busy, cal_done, cal_err,
                  ecrs, esn, ~esn, eb, ed, ee);
      end
   endtask

   task automatic check_row(input string tag, input int code, input bit b, input bit d, input bit e);
      logic [CRS_W-1:0] ecrs;
      logic [6:0]       esn;
      ecrs = CRS_W'(code / 8);
      esn  = sn_of(code);
      n_cmp++;
      if ({crs_code, fine_sn, fine_sp, cal_busy, cal_done, cal_err} !== {ecrs, esn, ~esn, b, d, e}) begin
         n_bad++;
         $display("FAIL %s cyc=%0d: got crs=%h sn=%h sp=%h bde=%b%b%b, want code=%0d bde=%b%b%b",
                  tag, cyc, crs_code, fine_sn, fine_sp, cal_busy, cal_done, cal_err, code, b, d, e);
      end
   endtask

   task automatic cycle();
      model_clock(cal_en, rb_dcc_byp, pd_up);
      @(posedge clk);
      #1;
      cyc++;
      check_model("cycle");
   endtask

   task automatic apply_reset();
      rstb = 1'b0;
      #2;
      model_reset();
      check_model("async_reset");
      #2;
      rstb = 1'b1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   typedef struct {
      string name;
      bit    rst;
      bit    en;
      bit    byp;
      int    pd;     // 0/1 constant level, 2 toggles every cycle
      int    ncyc;
      int    code;
      bit    busy;
      bit    done;
      bit    err;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int exp_dither[5] = '{65, 64, 65, 64, 65};
      int bias;

      tbl.push_back('{"reset_hold",   1, 0, 0, 0,    5,  64, 0, 0, 0});
      tbl.push_back('{"sat_pre_step", 0, 1, 0, 1,   25,  64, 1, 0, 0});
      tbl.push_back('{"sat_first",    0, 1, 0, 1,    1,  65, 1, 0, 0});
      tbl.push_back('{"sat_max",      0, 1, 0, 1, 1550, 127, 1, 0, 0});
      tbl.push_back('{"sat_err",      0, 1, 0, 1,   25, 127, 0, 0, 1});
      tbl.push_back('{"err_sticky",   0, 1, 0, 1,   10, 127, 0, 0, 1});
      tbl.push_back('{"err_clear",    0, 0, 0, 1,    1, 127, 0, 0, 0});
      tbl.push_back('{"byp_priority", 0, 1, 1, 1,    5, 127, 0, 0, 0});
      tbl.push_back('{"tie_run",      1, 1, 0, 2,  100,  64, 1, 0, 0});
      tbl.push_back('{"tie_lock",     0, 1, 0, 2,    1,  64, 0, 1, 0});
      tbl.push_back('{"tie_hold",     0, 1, 0, 2,   20,  64, 0, 1, 0});
      tbl.push_back('{"lock_exit",    0, 0, 0, 0,    1,  64, 0, 0, 0});

      model_reset();
      @(posedge clk);
      #1;
      apply_reset();

      foreach (tbl[k]) begin
         if (tbl[k].rst) apply_reset();
         for (int c = 0; c < tbl[k].ncyc; c++) begin
            cal_en     = tbl[k].en;
            rb_dcc_byp = tbl[k].byp;
            pd_up      = (tbl[k].pd == 2) ? (cyc % 2 == 1) : (tbl[k].pd == 1);
            cycle();
         end
         check_row(tbl[k].name, tbl[k].code, tbl[k].busy, tbl[k].done, tbl[k].err);
      end

      // Dither lock: one decision per iteration, alternating direction.
      apply_reset();
      cal_en = 1; rb_dcc_byp = 0;
      cycle();
      for (int i = 0; i < 5; i++) begin
         pd_up = (i % 2 == 0);
         run(25);
         check_row("dither_step", exp_dither[i], i < 4, i == 4, 0);
      end
      run(10);
      check_row("dither_hold", 65, 0, 1, 0);

      // Abort mid-sample, then restart from the retained code.
      apply_reset();
      cal_en = 1; pd_up = 1;
      run(76);
      check_row("abort_three_up", 67, 1, 0, 0);
      run(19);
      cal_en = 0;
      cycle();
      check_row("abort_idle", 67, 0, 0, 0);
      cal_en = 1; pd_up = 0;
      run(26);
      check_row("abort_restart", 66, 1, 0, 0);

      // Bypass during settle, release restarts settle next cycle.
      apply_reset();
      cal_en = 1; pd_up = 1;
      run(6);
      rb_dcc_byp = 1;
      cycle();
      check_row("byp_enter", 64, 0, 0, 0);
      run(3);
      rb_dcc_byp = 0;
      cycle();
      check_row("byp_release", 64, 1, 0, 0);
      run(24);
      check_row("byp_pre_step", 64, 1, 0, 0);
      cycle();
      check_row("byp_step", 65, 1, 0, 0);
      run(7);
      apply_reset();
      check_row("midop_reset", 64, 0, 0, 0);

      // Randomized run with per-iteration pd bias and rare enable/bypass glitches.
      bias = 50;
      for (int i = 0; i < 4000; i++) begin
         if (i % 25 == 0) bias = 25 * int'($urandom_range(0, 4));
         pd_up      = (int'($urandom_range(0, 99)) < bias);
         cal_en     = ($urandom_range(0, 299) != 0);
         rb_dcc_byp = ($urandom_range(0, 399) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
